// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester and the APB slaves (GPIO, UART):
// bus widths, slave slot indices and the requester state encoding.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int NUM_SLAVES = 2;

  localparam int GPIO_SLOT = 0;
  localparam int UART_SLOT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b11
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_addr_decode
// Combinational slave decode for the APB requester.
//   cmd_addr    in   byte address of the pending command
//   psel_onehot out  one-hot slave select (bit SEL_BIT picks UART over GPIO)
//   decode_err  out  address has bits set above SEL_BIT (no slave there)
// ---------------------------------------------------------------------------
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int SEL_BIT = 12
) (
  input  logic [ADDR_W-1:0]     cmd_addr,
  output logic [NUM_SLAVES-1:0] psel_onehot,
  output logic                  decode_err
);

  logic [ADDR_W-1:0] upper_bits;

  always_comb begin
    upper_bits  = cmd_addr >> (SEL_BIT + 1);
    decode_err  = (upper_bits != '0);
    psel_onehot = '0;
    if (cmd_addr[SEL_BIT]) begin
      psel_onehot[UART_SLOT] = 1'b1;
    end else begin
      psel_onehot[GPIO_SLOT] = 1'b1;
    end
  end

endmodule : apb_addr_decode

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// Turns single-beat commands from an internal initiator into APB4
// SETUP/ACCESS transfers, with a watchdog that aborts transfers whose
// slave never raises PREADY.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | PSEL/PENABLE low, cmd_ready high; decode errors answered here
//   SETUP  | PSEL high, PENABLE low for one cycle; watchdog loaded
//   ACCESS | PENABLE high; wait for PREADY or watchdog terminal count
//
// Ports
//   PCLK, PRESETn            clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = state is IDLE)
//   cmd_write/addr/wdata/strb command payload
//   rsp_valid/rdata/err      one-cycle response pulse, no backpressure
//   PADDR..PENABLE           APB requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR    APB completer returns
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int SEL_BIT = 12
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [STRB_W-1:0]     cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [STRB_W-1:0]     PSTRB,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Watchdog is a down-counter loaded in SETUP with TIMEOUT-1; reaching zero
  // while PREADY is still low marks the TIMEOUT-th ACCESS cycle.
  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              WD_EN   = (TIMEOUT != 0);

  apb_state_e            state_q, state_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [ADDR_W-1:0]     paddr_d;
  logic                  pwrite_d;
  logic [DATA_W-1:0]     pwdata_d;
  logic [STRB_W-1:0]     pstrb_d;
  logic [NUM_SLAVES-1:0] psel_d;
  logic                  penable_d;
  logic                  rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_d;
  logic                  rsp_err_d;

  logic [NUM_SLAVES-1:0] dec_psel;
  logic                  dec_err;

  apb_addr_decode #(
    .SEL_BIT (SEL_BIT)
  ) u_addr_decode (
    .cmd_addr    (cmd_addr),
    .psel_onehot (dec_psel),
    .decode_err  (dec_err)
  );

  assign cmd_ready = (state_q == IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        wd_d      = '0;
        if (cmd_valid) begin
          if (dec_err) begin
            // Unmapped address: answer immediately, leave the bus untouched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = SETUP;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_strb : '0;
            psel_d   = dec_psel;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wd_d      = WD_LOAD;
      end

      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          wd_d        = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!PWRITE && !PSLVERR) ? PRDATA : '0;
        end else if (WD_EN && (wd_q == '0)) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          wd_d        = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (WD_EN) begin
          wd_d = wd_q - WD_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
        wd_d      = '0;
      end
    endcase
  end

endmodule : apb_master

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Randomized and directed stimulus for apb_master against a transaction-level
// reference model (expected response, latency and bus contents per command).
// ---------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int SEL_BIT = 12;

  logic                  PCLK;
  logic                  PRESETn;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [STRB_W-1:0]     cmd_strb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_W-1:0]     PADDR;
  logic                  PWRITE;
  logic [DATA_W-1:0]     PWDATA;
  logic [STRB_W-1:0]     PSTRB;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  int n_chk = 0;
  int n_bad = 0;

  // slave behaviour for the current transfer
  int          w_cur      = 0;
  logic        slverr_cur = 1'b0;
  logic [31:0] prdata_cur = '0;
  int          acc_i      = 0;

  apb_master #(
    .TIMEOUT (TIMEOUT),
    .SEL_BIT (SEL_BIT)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Completer: PREADY rises in the (w_cur+1)-th ACCESS cycle; junk data before.
  always @(negedge PCLK) begin
    if (PSEL != '0 && PENABLE) begin
      if (acc_i == w_cur) begin
        PREADY  = 1'b1;
        PRDATA  = prdata_cur;
        PSLVERR = slverr_cur;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
      acc_i++;
    end else begin
      acc_i   = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;
    end
  end

  // Issues one command (caller is at a negedge) and checks it end to end.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int w, input logic serr,
                         input logic [31:0] rd, input bit b2b);
    logic        dec;
    logic [1:0]  epsel;
    logic [31:0] epwdata;
    logic [3:0]  epstrb;
    int          exp_k;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          k;
    bit          got;

    dec     = ((addr >> (SEL_BIT + 1)) != 32'h0);
    epsel   = addr[SEL_BIT] ? 2'b10 : 2'b01;
    epwdata = wr ? wdata : 32'h0;
    epstrb  = wr ? strb : 4'h0;
    if (dec) begin
      exp_k = 1;  exp_err = 1'b1;  exp_rd = 32'h0;
    end else if (w < TIMEOUT) begin
      exp_k   = 3 + w;
      exp_err = serr;
      exp_rd  = (!wr && !serr) ? rd : 32'h0;
    end else begin
      exp_k = 2 + TIMEOUT;  exp_err = 1'b1;  exp_rd = 32'h0;
    end

    w_cur      = w;
    slverr_cur = serr;
    prdata_cur = rd;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    cmd_strb   = strb;
    cmd_valid  = 1'b1;
    chk("cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge PCLK);

    k   = 0;
    got = 0;
    while (!got && k < 40) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      k++;
      if (rsp_valid) begin
        got = 1;
      end else if (dec) begin
        chk("dec_psel", 32'(PSEL), 32'h0);
      end else begin
        chk("psel", 32'(PSEL), 32'(epsel));
        chk("penable", 32'(PENABLE), (k == 1) ? 32'h0 : 32'h1);
        chk("paddr", PADDR, addr);
        chk("pwrite", 32'(PWRITE), 32'(wr));
        chk("pwdata", PWDATA, epwdata);
        chk("pstrb", 32'(PSTRB), 32'(epstrb));
      end
    end
    chk("rsp_seen", 32'(got), 32'h1);
    chk("latency", 32'(k), 32'(exp_k));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel", 32'(PSEL), 32'h0);
    chk("rsp_penable", 32'(PENABLE), 32'h0);
    if (!b2b) begin
      @(negedge PCLK);
      chk("rsp_pulse", 32'(rsp_valid), 32'h0);
    end
  endtask

  initial begin
    logic        wr;
    logic [31:0] addr;
    int          w;
    int          r;
    bit          b2b;

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;

    #12;
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pstrb", 32'(PSTRB), 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_ready", 32'(cmd_ready), 32'h1);

    // directed cases
    run_cmd(1'b1, 32'h0000_0001, 32'h0000_00A5, 4'b0001, 0, 1'b0, 32'h0, 0);
    run_cmd(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 2, 1'b0, 32'h1234_5678, 0);
    run_cmd(1'b1, 32'h0000_0004, 32'h5555_AAAA, 4'b0011, 1, 1'b1, 32'h0, 0);
    run_cmd(1'b0, 32'h0000_1008, 32'h0, 4'h0, 1000, 1'b0, 32'h7777_7777, 0);
    run_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, 0);
    run_cmd(1'b0, 32'h0000_1014, 32'h0, 4'h0, TIMEOUT, 1'b0, 32'h1111_2222, 0);
    run_cmd(1'b1, 32'h0001_0000, 32'h0000_0001, 4'b1111, 0, 1'b0, 32'h0, 0);
    run_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 1'b0, 32'hA0A0_0001, 1);
    run_cmd(1'b0, 32'h0000_1024, 32'h0, 4'h0, 0, 1'b0, 32'hA0A0_0002, 1);
    run_cmd(1'b0, 32'h0000_0028, 32'h0, 4'h0, 0, 1'b0, 32'hA0A0_0003, 0);

    // reset in the middle of an ACCESS phase
    w_cur     = 1000;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_1030;
    cmd_valid = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("pre_rst_penable", 32'(PENABLE), 32'h1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(PSEL), 32'h0);
    chk("mid_rst_penable", 32'(PENABLE), 32'h0);
    chk("mid_rst_paddr", PADDR, 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) begin
      @(negedge PCLK);
      chk("mid_rst_norsp", 32'(rsp_valid), 32'h0);
    end
    PRESETn = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      chk("post_rst_norsp", 32'(rsp_valid), 32'h0);
      chk("post_rst_psel", 32'(PSEL), 32'h0);
    end
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = {19'h0, 1'($urandom_range(0, 1)), 12'($urandom)};
      if ($urandom_range(0, 7) == 0)
        addr = addr | (32'($urandom_range(1, 7)) << (13 + $urandom_range(0, 16)));
      r = int'($urandom_range(0, 9));
      if (r <= 5)      w = int'($urandom_range(0, 3));
      else if (r == 6) w = TIMEOUT - 1;
      else if (r == 7) w = TIMEOUT;
      else if (r == 8) w = TIMEOUT + 5;
      else             w = 0;
      b2b = (i != 79) && ($urandom_range(0, 1) == 1);
      run_cmd(wr, addr, $urandom, 4'($urandom), w, ($urandom_range(0, 3) == 0),
              $urandom, b2b);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_apb_master

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat commands from an internal initiator (CPU-side bus or test sequencer) into APB4 SETUP/ACCESS transfers toward the peripheral slaves (GPIO at slot 0, UART at slot 1). It decodes the target slave, holds all APB signals stable across wait states, and returns read data and error status per command. A watchdog aborts transfers whose slave never asserts PREADY.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles before abort; 0 disables the watchdog.
- SEL_BIT, 12: PADDR bit selecting slave 1 (1) or slave 0 (0).
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command (combinational: state==IDLE).
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  PSLVERR, decode error or timeout.
- PADDR  out  32; PWRITE  out  1; PWDATA  out  32; PSTRB  out  4.
- PSEL  out  2  one-hot slave select.
- PENABLE  out  1  ACCESS phase.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.

## Operation
- States: IDLE, SETUP, ACCESS. All APB outputs, rsp_* registered.
- Reset: state=IDLE, PADDR/PWDATA/PRDATA capture/PSTRB/PWRITE=0, PSEL=2'b00, PENABLE=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, watchdog count=0; cmd_ready=1 once PRESETn high.
- IDLE: on cmd_valid&&cmd_ready latch command. Decode: cmd_addr[31:SEL_BIT+1]!=0 -> decode error: no APB activity, stay IDLE, rsp_valid=1, rsp_err=1 next cycle. Else -> SETUP with PSEL[cmd_addr[SEL_BIT]]=1, PENABLE=0.
- Reads drive PSTRB=4'b0000, PWDATA=0; writes drive cmd_strb/cmd_wdata unmodified (strobe legality is the slave's concern).
- SETUP: unconditionally -> ACCESS, PENABLE=1.
- ACCESS: PADDR/PWRITE/PWDATA/PSTRB/PSEL held stable. PREADY=1 -> complete: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA if read and !PSLVERR else 0; -> IDLE.
- Watchdog: counts ACCESS cycles with PREADY=0; sampling PREADY=0 in the TIMEOUT-th ACCESS cycle -> abort exactly as completion with rsp_err=1, rsp_rdata=0. PREADY=1 in that same cycle wins (normal completion). Counter clears on leaving ACCESS.
- PSEL=0 and PENABLE=0 in IDLE; PADDR etc. retain last values.
- Reset mid-transfer: all outputs return to reset values immediately; no response issued.

## Timing
- Command accepted at edge T: SETUP visible T..T+1, ACCESS from T+1; zero-wait completion at edge T+2, rsp_valid high cycle after T+2 (3-cycle latency).
- Each wait state (PREADY=0) adds one cycle.
- Decode error: rsp_valid high the cycle after acceptance.
- Back-to-back: cmd_ready high in the cycle rsp_valid is high; next SETUP begins one cycle after that acceptance; minimum 3 cycles per transfer, one idle APB cycle between transfers.
- rsp_valid is exactly one cycle wide.

## Structure
- Package apb_pkg: state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b11), slot indices (GPIO_SLOT=0, UART_SLOT=1), shared 32-bit address/data widths; reused by the GPIO and UART slaves.
- Sub-module apb_addr_decode: combinational cmd_addr -> PSEL one-hot + decode_err.

## Test plan
- Write 0x000000A5, strb 0001, addr 0x0000_0001, PREADY=1 -> PSEL=01 with PENABLE 0 then 1, PSTRB=0001, rsp_valid 3 cycles after accept, rsp_err=0.
- Read addr 0x0000_1000, slave returns PRDATA=0x1234_5678 after 2 wait states -> PSEL=10, PSTRB=0000, PADDR stable 4 cycles, rsp_rdata=0x1234_5678.
- Write with slave PSLVERR=1 (strb 0011) -> rsp_err=1, rsp_rdata=0.
- PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, PSEL/PENABLE drop, rsp_err=1; PREADY=1 on cycle 16 -> normal completion.
- Addr 0x0001_0000 -> no PSEL activity, rsp_valid next cycle, rsp_err=1; back-to-back reads issue one per 3 cycles; PRESETn low during ACCESS -> outputs reset, no rsp_valid.
